// File: rtl/tracking_pkg.sv
// rtl/tracking_pkg.sv - shared types and helpers for the colour bounding-box tracker
package tracking_pkg;

   localparam int BBOX_COORD_W = 12;
   localparam int BBOX_COUNT_W = 20;

   typedef enum logic {ACCUM = 1'b0, REPORT = 1'b1} track_state_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      rgb_t lo;
      rgb_t hi;
   } threshold_t;

   typedef struct packed {
      logic                    found;
      logic [BBOX_COORD_W-1:0] center_x;
      logic [BBOX_COORD_W-1:0] center_y;
      logic [BBOX_COORD_W-1:0] width;
      logic [BBOX_COORD_W-1:0] height;
      logic [BBOX_COUNT_W-1:0] count;
   } bbox_t;

   // lo above hi on every channel: nothing can match
   localparam threshold_t THR_DISABLED = 48'hFFFFFF_000000;

   function automatic logic in_window(input rgb_t p, input threshold_t t);
      return (p.r >= t.lo.r) && (p.r <= t.hi.r) &&
             (p.g >= t.lo.g) && (p.g <= t.hi.g) &&
             (p.b >= t.lo.b) && (p.b <= t.hi.b);
   endfunction

endpackage

// File: rtl/bbox_accum.sv
// rtl/bbox_accum.sv - per-class colour match and min/max/count box accumulator
// The live box clears as the eof pixel retires, while a snapshot holds the finished frame for reporting.
module bbox_accum
   import tracking_pkg::*;
#(
   parameter int COORD_W = 12,
   parameter int COUNT_W = 20
) (
   input  logic               clock_50,
   input  logic               reset,
   input  logic               clear,
   input  rgb_t               s1_pixel,
   input  threshold_t         thr,
   input  logic               s2_valid,
   input  logic               s2_eof,
   input  logic [COORD_W-1:0] s2_x,
   input  logic [COORD_W-1:0] s2_y,
   output logic [COORD_W-1:0] min_x,
   output logic [COORD_W-1:0] max_x,
   output logic [COORD_W-1:0] min_y,
   output logic [COORD_W-1:0] max_y,
   output logic [COUNT_W-1:0] count
);

   logic               match_q;
   logic [COORD_W-1:0] live_min_x, live_max_x, live_min_y, live_max_y;
   logic [COUNT_W-1:0] live_cnt;
   logic [COORD_W-1:0] nxt_min_x, nxt_max_x, nxt_min_y, nxt_max_y;
   logic [COUNT_W-1:0] nxt_cnt;
   logic               retire_eof;

   assign retire_eof = s2_valid && s2_eof;

   always_comb begin
      nxt_min_x = live_min_x;
      nxt_max_x = live_max_x;
      nxt_min_y = live_min_y;
      nxt_max_y = live_max_y;
      nxt_cnt   = live_cnt;
      if (s2_valid && match_q) begin
         if (live_cnt == '0) begin
            nxt_min_x = s2_x;
            nxt_max_x = s2_x;
            nxt_min_y = s2_y;
            nxt_max_y = s2_y;
            nxt_cnt   = COUNT_W'(1);
         end else begin
            if (s2_x < live_min_x) nxt_min_x = s2_x;
            if (s2_x > live_max_x) nxt_max_x = s2_x;
            if (s2_y < live_min_y) nxt_min_y = s2_y;
            if (s2_y > live_max_y) nxt_max_y = s2_y;
            if (live_cnt != '1) nxt_cnt = live_cnt + COUNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         match_q    <= 1'b0;
         live_min_x <= '0;
         live_max_x <= '0;
         live_min_y <= '0;
         live_max_y <= '0;
         live_cnt   <= '0;
         min_x      <= '0;
         max_x      <= '0;
         min_y      <= '0;
         max_y      <= '0;
         count      <= '0;
      end else begin
         match_q <= in_window(s1_pixel, thr);
         if (retire_eof) begin
            min_x <= nxt_min_x;
            max_x <= nxt_max_x;
            min_y <= nxt_min_y;
            max_y <= nxt_max_y;
            count <= nxt_cnt;
         end
         if (clear || retire_eof) begin
            live_min_x <= '0;
            live_max_x <= '0;
            live_min_y <= '0;
            live_max_y <= '0;
            live_cnt   <= '0;
         end else begin
            live_min_x <= nxt_min_x;
            live_max_x <= nxt_max_x;
            live_min_y <= nxt_min_y;
            live_max_y <= nxt_max_y;
            live_cnt   <= nxt_cnt;
         end
      end
   end

endmodule

// File: rtl/color_bbox_tracker.sv
// rtl/color_bbox_tracker.sv - multi-class RGB window bounding-box tracker over a raster pixel stream
module color_bbox_tracker
   import tracking_pkg::*;
#(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int NUM_CLASSES = 4,
   parameter int COORD_W     = 12,
   parameter int COUNT_W     = 20,
   parameter int MIN_PIXELS  = 16,
   localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic               clock_50,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sof,
   input  logic [23:0]        in_pixel,
   input  logic               cfg_wr_en,
   input  logic [CLS_W-1:0]   cfg_class,
   input  logic [23:0]        cfg_lo,
   input  logic [23:0]        cfg_hi,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLS_W-1:0]   out_class,
   output logic               out_found,
   output logic [COORD_W-1:0] center_x,
   output logic [COORD_W-1:0] center_y,
   output logic [COORD_W-1:0] width,
   output logic [COORD_W-1:0] height,
   output logic [COUNT_W-1:0] pixel_count
);

   localparam logic [0:0] ST_ACCUM  = ACCUM;
   localparam logic [0:0] ST_REPORT = REPORT;

   logic [0:0]         state;
   logic [CLS_W-1:0]   rpt_idx;
   logic               ready_en;
   logic               accept, abort;
   logic [COORD_W-1:0] x_cnt, y_cnt, px, py;
   logic               last_x, last_y;
   threshold_t         shadow_thr [NUM_CLASSES];
   threshold_t         shadow_nxt [NUM_CLASSES];
   threshold_t         active_thr [NUM_CLASSES];
   logic               s1_valid, s1_eof, s2_valid, s2_eof;
   rgb_t               s1_pixel;
   logic [COORD_W-1:0] s1_x, s1_y, s2_x, s2_y;
   logic [COORD_W-1:0] snap_min_x [NUM_CLASSES];
   logic [COORD_W-1:0] snap_max_x [NUM_CLASSES];
   logic [COORD_W-1:0] snap_min_y [NUM_CLASSES];
   logic [COORD_W-1:0] snap_max_y [NUM_CLASSES];
   logic [COUNT_W-1:0] snap_cnt   [NUM_CLASSES];
   logic [COORD_W:0]   sum_x, sum_y;
   bbox_t              rec;

   assign in_ready  = ready_en && (state == ST_ACCUM);
   assign out_valid = (state == ST_REPORT);
   assign accept    = in_valid && in_ready;
   // a sof anywhere but the expected (0,0) throws away the partial frame
   assign abort     = accept && in_sof && ((x_cnt != '0) || (y_cnt != '0));

   always_comb begin
      px     = in_sof ? '0 : x_cnt;
      py     = in_sof ? '0 : y_cnt;
      last_x = (px == COORD_W'(WIDTH - 1));
      last_y = (py == COORD_W'(HEIGHT - 1));
   end

   always_comb begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
         shadow_nxt[k] = shadow_thr[k];
         if (cfg_wr_en && (cfg_class == CLS_W'(k))) shadow_nxt[k] = {cfg_lo, cfg_hi};
      end
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         for (int k = 0; k < NUM_CLASSES; k++) begin
            shadow_thr[k] <= THR_DISABLED;
            active_thr[k] <= THR_DISABLED;
         end
      end else begin
         for (int k = 0; k < NUM_CLASSES; k++) begin
            shadow_thr[k] <= shadow_nxt[k];
            if (accept && in_sof) active_thr[k] <= shadow_nxt[k];
         end
      end
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         x_cnt    <= '0;
         y_cnt    <= '0;
         s1_valid <= 1'b0;
         s1_eof   <= 1'b0;
         s1_pixel <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
         s2_valid <= 1'b0;
         s2_eof   <= 1'b0;
         s2_x     <= '0;
         s2_y     <= '0;
      end else begin
         if (accept) begin
            x_cnt <= last_x ? '0 : px + COORD_W'(1);
            y_cnt <= last_x ? (last_y ? '0 : py + COORD_W'(1)) : py;
         end
         s1_valid <= accept;
         s1_eof   <= last_x && last_y;
         s1_pixel <= in_pixel;
         s1_x     <= px;
         s1_y     <= py;
         s2_valid <= s1_valid && !abort;
         s2_eof   <= s1_eof;
         s2_x     <= s1_x;
         s2_y     <= s1_y;
      end
   end

   for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cls
      bbox_accum #(
         .COORD_W (COORD_W),
         .COUNT_W (COUNT_W)
      ) u_accum (
         .clock_50 (clock_50),
         .reset    (reset),
         .clear    (abort),
         .s1_pixel (s1_pixel),
         .thr      (active_thr[k]),
         .s2_valid (s2_valid),
         .s2_eof   (s2_eof),
         .s2_x     (s2_x),
         .s2_y     (s2_y),
         .min_x    (snap_min_x[k]),
         .max_x    (snap_max_x[k]),
         .min_y    (snap_min_y[k]),
         .max_y    (snap_max_y[k]),
         .count    (snap_cnt[k])
      );
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         state    <= ST_ACCUM;
         rpt_idx  <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         case (state)
            ST_ACCUM: begin
               rpt_idx <= '0;
               if (s2_valid && s2_eof) state <= ST_REPORT;
            end
            default: begin
               if (out_ready) begin
                  if (rpt_idx == CLS_W'(NUM_CLASSES - 1)) begin
                     state   <= ST_ACCUM;
                     rpt_idx <= '0;
                  end else begin
                     rpt_idx <= rpt_idx + CLS_W'(1);
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      rec   = '0;
      sum_x = {1'b0, snap_min_x[rpt_idx]} + {1'b0, snap_max_x[rpt_idx]};
      sum_y = {1'b0, snap_min_y[rpt_idx]} + {1'b0, snap_max_y[rpt_idx]};
      if (out_valid && (snap_cnt[rpt_idx] != '0)) begin
         rec.found    = (snap_cnt[rpt_idx] >= COUNT_W'(MIN_PIXELS));
         rec.center_x = BBOX_COORD_W'(sum_x >> 1);
         rec.center_y = BBOX_COORD_W'(sum_y >> 1);
         rec.width    = BBOX_COORD_W'(snap_max_x[rpt_idx] - snap_min_x[rpt_idx] + COORD_W'(1));
         rec.height   = BBOX_COORD_W'(snap_max_y[rpt_idx] - snap_min_y[rpt_idx] + COORD_W'(1));
         rec.count    = BBOX_COUNT_W'(snap_cnt[rpt_idx]);
      end
   end

   assign out_class   = rpt_idx;
   assign out_found   = rec.found;
   assign center_x    = COORD_W'(rec.center_x);
   assign center_y    = COORD_W'(rec.center_y);
   assign width       = COORD_W'(rec.width);
   assign height      = COORD_W'(rec.height);
   assign pixel_count = COUNT_W'(rec.count);

endmodule

// File: tb/tb_color_bbox_tracker.sv
// tb/tb_color_bbox_tracker.sv - directed scoreboard bench for color_bbox_tracker
`timescale 1ns/1ps
module tb_color_bbox_tracker;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int NC = 2;
   localparam int CW = 12;
   localparam int NW = 20;
   localparam logic [23:0] GREEN = 24'h00FF00;

   logic          clock_50 = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, in_sof;
   logic [23:0]   in_pixel;
   logic          cfg_wr_en;
   logic [0:0]    cfg_class;
   logic [23:0]   cfg_lo, cfg_hi;
   logic          out_valid, out_ready;
   logic [0:0]    out_class;
   logic          out_found;
   logic [CW-1:0] center_x, center_y, width, height;
   logic [NW-1:0] pixel_count;

   typedef struct {
      int cls;
      int found;
      int cx;
      int cy;
      int w;
      int h;
      int cnt;
   } rec_t;

   rec_t        exp_q[$];
   rec_t        mon_e;
   logic [23:0] frame [W*H];
   int          checks   = 0;
   int          failures = 0;

   always #10 clock_50 = ~clock_50;

   color_bbox_tracker #(
      .WIDTH       (W),
      .HEIGHT      (H),
      .NUM_CLASSES (NC),
      .COORD_W     (CW),
      .COUNT_W     (NW),
      .MIN_PIXELS  (2)
   ) dut (
      .clock_50    (clock_50),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sof      (in_sof),
      .in_pixel    (in_pixel),
      .cfg_wr_en   (cfg_wr_en),
      .cfg_class   (cfg_class),
      .cfg_lo      (cfg_lo),
      .cfg_hi      (cfg_hi),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_class   (out_class),
      .out_found   (out_found),
      .center_x    (center_x),
      .center_y    (center_y),
      .width       (width),
      .height      (height),
      .pixel_count (pixel_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push_rec(input int cls, input int found, input int cx, input int cy,
                           input int w, input int h, input int cnt);
      rec_t r;
      r.cls = cls; r.found = found; r.cx = cx; r.cy = cy; r.w = w; r.h = h; r.cnt = cnt;
      exp_q.push_back(r);
   endtask

   task automatic push_zero(input int cls);
      push_rec(cls, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic fill(input logic [23:0] v);
      for (int i = 0; i < W*H; i++) frame[i] = v;
   endtask

   task automatic fill_box();
      fill(24'h000000);
      frame[1*W+2] = GREEN;
      frame[1*W+5] = GREEN;
      frame[2*W+2] = GREEN;
      frame[2*W+5] = GREEN;
   endtask

   task automatic cfg_write(input int cls, input logic [23:0] lo, input logic [23:0] hi);
      cfg_wr_en = 1'b1; cfg_class = cls[0:0]; cfg_lo = lo; cfg_hi = hi;
      @(posedge clock_50); #1;
      cfg_wr_en = 1'b0;
   endtask

   task automatic send_pix(input logic sof, input logic [23:0] pix, input logic cfg);
      int n = 0;
      in_valid = 1'b1; in_sof = sof; in_pixel = pix; cfg_wr_en = cfg;
      @(negedge clock_50);
      while (!in_ready && n < 100) begin
         @(negedge clock_50);
         n++;
      end
      checks++;
      assert (in_ready) else begin
         failures++;
         $error("FAIL in_ready_timeout observed=0 expected=1");
      end
      @(posedge clock_50); #1;
      in_valid = 1'b0; in_sof = 1'b0; cfg_wr_en = 1'b0;
   endtask

   task automatic send_frame(input int cfg_idx);
      for (int i = 0; i < W*H; i++) send_pix(i == 0, frame[i], i == cfg_idx);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
         @(negedge clock_50);
         n++;
      end
      checks++;
      assert (n < 300) else begin
         failures++;
         $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
      end
   endtask

   task automatic wait_out_valid();
      int n = 0;
      @(negedge clock_50);
      while (!out_valid && n < 100) begin
         @(negedge clock_50);
         n++;
      end
      check("out_valid_wait", out_valid, 1);
   endtask

   always @(negedge clock_50) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_record observed=class%0d expected=none", out_class);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("rec_class", out_class, mon_e.cls);
            check("rec_found", out_found, mon_e.found);
            check("rec_center_x", center_x, mon_e.cx);
            check("rec_center_y", center_y, mon_e.cy);
            check("rec_width", width, mon_e.w);
            check("rec_height", height, mon_e.h);
            check("rec_count", pixel_count, mon_e.cnt);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=hang expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
      cfg_wr_en = 1'b0; cfg_class = '0; cfg_lo = '0; cfg_hi = '0; out_ready = 1'b1;
      @(posedge clock_50); #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_found", out_found, 0);
      check("rst_center_x", center_x, 0);
      check("rst_width", width, 0);
      check("rst_count", pixel_count, 0);
      reset = 1'b0;
      @(posedge clock_50); #1;
      check("ready_after_reset", in_ready, 1);

      // single class box, with eof-to-out_valid latency
      cfg_write(0, 24'h003200, 24'h32FF32);
      fill_box();
      push_rec(0, 1, 3, 1, 4, 2, 4);
      push_zero(1);
      for (int i = 0; i < W*H-1; i++) send_pix(i == 0, frame[i], 1'b0);
      send_pix(1'b0, frame[W*H-1], 1'b0);
      @(negedge clock_50);
      check("lat_t1_valid", out_valid, 0);
      @(negedge clock_50);
      check("lat_t2_valid", out_valid, 0);
      check("lat_t2_ready", in_ready, 1);
      @(negedge clock_50);
      check("lat_t3_valid", out_valid, 1);
      check("lat_t3_ready", in_ready, 0);
      wait_drain();

      // backpressure: record held stable with out_ready low
      out_ready = 1'b0;
      push_rec(0, 1, 3, 1, 4, 2, 4);
      push_zero(1);
      send_frame(-1);
      wait_out_valid();
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_class", out_class, 0);
         check("bp_center_x", center_x, 3);
         check("bp_width", width, 4);
         check("bp_count", pixel_count, 4);
         @(negedge clock_50);
      end
      @(posedge clock_50); #1;
      out_ready = 1'b1;
      wait_drain();

      // config written mid-frame takes effect next frame; frames back to back
      cfg_class = 1'b1; cfg_lo = 24'h000000; cfg_hi = 24'hFFFFFF;
      fill(24'h000000);
      push_zero(0);
      push_zero(1);
      push_zero(0);
      push_rec(1, 1, 3, 1, 8, 4, 32);
      send_frame(12);
      send_frame(-1);
      wait_drain();

      // mid-frame sof aborts the partial frame
      for (int i = 0; i < 10; i++) send_pix(i == 0, GREEN, 1'b0);
      fill_box();
      push_rec(0, 1, 3, 1, 4, 2, 4);
      push_rec(1, 1, 3, 1, 8, 4, 32);
      send_frame(-1);
      wait_drain();

      // single pixel below MIN_PIXELS
      fill(24'h000000);
      frame[3*W+6] = GREEN;
      push_rec(0, 0, 6, 3, 1, 1, 1);
      push_rec(1, 1, 3, 1, 8, 4, 32);
      send_frame(-1);
      wait_drain();

      // reset during REPORT
      fill(GREEN);
      out_ready = 1'b0;
      send_frame(-1);
      wait_out_valid();
      @(posedge clock_50); #1;
      reset = 1'b1;
      @(posedge clock_50); #1;
      check("rpt_rst_out_valid", out_valid, 0);
      check("rpt_rst_in_ready", in_ready, 0);
      check("rpt_rst_count", pixel_count, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clock_50); #1;
      check("rpt_rst_ready_back", in_ready, 1);
      push_zero(0);
      push_zero(1);
      send_frame(-1);
      wait_drain();

      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
